pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning the width of the measurement counters and the PERIOD, HIGH and TIMEOUT registers (legal range 8..32).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1 bit: bus request qualifier (cyc&stb&instance select).
REQ-005 SHALL have port ready_o, output, 1 bit: bus acknowledge.
REQ-006 SHALL have port we_i, input, 1 bit: 1 means write, 0 means read.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address; only addr_i[4:2] is decoded.
REQ-008 SHALL have port wdata_i, input, 32 bits: write data.
REQ-009 SHALL have port rdata_o, output, 32 bits: read data.
REQ-010 SHALL have port cio_pwm_i, input, 1 bit: asynchronous PWM pad input.
REQ-011 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-012 Register map:
- 0x00 CTRL RW: bit0 EN, bit1 IRQ_EN; bit2 CLR, write-1 self-clearing, reads 0.
- 0x04 PERIOD RO.
- 0x08 HIGH RO.
- 0x0C STATUS: bit0 VALID (W1C), bit1 OVF (W1C), bit2 LEVEL (RO, synchronized input).
- 0x10 TIMEOUT RW; 0 = disabled.
- Unmapped offsets read 0 and ignore writes.
REQ-013 Handshake:
- ready_o SHALL be 1 in cycle N+1 when valid_i=1 and ready_o=0 in cycle N; otherwise 0.
- rdata_o SHALL be valid while ready_o=1 and 0 otherwise.
- Writes SHALL take effect at the edge that raises ready_o.
- Back-to-back requests are acknowledged every second cycle.
REQ-014 cio_pwm_i SHALL pass through a 2-flop synchronizer followed by a delay flop; rise = sync & ~delay.
REQ-015 States: IDLE (EN=0), ARM (waiting for first rise), MEAS.
- IDLE -> ARM when EN=1.
- ARM -> MEAS on rise.
- MEAS -> ARM on overflow or CLR.
- Any state -> IDLE when EN=0.
REQ-016 Rise in ARM: cnt <= 0, hcnt <= 1.
REQ-017 Rise in MEAS: PERIOD <= cnt+1, HIGH <= hcnt, VALID <= 1, then cnt <= 0, hcnt <= 1.
REQ-018 No rise in MEAS: cnt increments; hcnt increments while LEVEL=1; both saturate at all-ones.
REQ-019 Overflow in MEAS: when cnt+1 equals TIMEOUT (TIMEOUT≠0) or cnt is all-ones with no rise, SHALL set OVF, go to ARM and leave PERIOD/HIGH unchanged.
REQ-020 Latency: PERIOD/HIGH/VALID SHALL update on the third clock edge that samples cio_pwm_i high (the first sampling edge counts as 1).
REQ-021 Simultaneous events: a hardware set of VALID/OVF in the same cycle as a software W1C SHALL win; a rise in the same cycle as overflow SHALL be treated as a rise.
REQ-022 CLR SHALL zero PERIOD, HIGH, VALID, OVF and the counters, and go to ARM if EN=1.
REQ-023 Clearing EN mid-measurement SHALL zero the counters and retain PERIOD, HIGH and the flags.
REQ-024 irq_o SHALL be registered: IRQ_EN & (VALID | OVF).

Reset
REQ-025 rst_ni low SHALL asynchronously force:
- state IDLE;
- all registers, counters and synchronizer flops to 0;
- ready_o=0, rdata_o=0, irq_o=0.
REQ-026 Reset asserted mid-transaction SHALL drop the transaction; no ready_o is issued for it.

Structure
REQ-027 The register offsets, CTRL/STATUS bit positions and the state enum SHALL live in shared package pwm_pkg.
REQ-028 The synchronizer SHALL be sub-module prim_sync_2ff (parameterizable width, async active-low reset); all other logic SHALL be in pwm_capture.

Verification
REQ-029 Write CTRL=1, drive a period of 10 clocks with 3 high -> PERIOD=10, HIGH=3, VALID=1 after the second rise; read ack exactly 1 cycle after valid_i.
REQ-030 Set TIMEOUT=50 and hold the input low (then high) -> OVF=1 at cnt+1=50, state ARM; with IRQ_EN=1, irq_o rises the next cycle.
REQ-031 W1C of VALID issued in the same cycle as a new capture -> VALID reads 1.
REQ-032 Write CLR mid-period -> PERIOD=HIGH=0, flags 0; the next full period of 20 clocks with 5 high is measured correctly as PERIOD=20, HIGH=5.
REQ-033 Pulse rst_ni low mid-measurement and mid-read -> all outputs 0 immediately, no ack; CTRL reads 0 afterwards.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: register word offsets,
// CTRL/STATUS bit positions and the measurement state encoding.
package pwm_pkg;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_PERIOD  = 3'd1;
  localparam logic [2:0] OFF_HIGH    = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_TIMEOUT = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_LEVEL = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/prim_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module prim_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_p0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_p0 <= '0;
      q_o      <= '0;
    end else begin
      stage_p0 <= d_i;
      q_o      <= stage_p0;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with a small register bus, overflow
// timeout and a level interrupt.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        cio_pwm_i,
  output logic        irq_o
);

  function automatic logic [BITS-1:0] sat_inc(input logic [BITS-1:0] v);
    return (&v) ? v : v + BITS'(1);
  endfunction

  pwm_state_e      state;
  logic            lvl_sync, lvl_p2, rise;
  logic            en, irq_en, st_valid, st_ovf;
  logic [BITS-1:0] cnt, hcnt, period, high, timeout;
  logic [BITS:0]   cnt_inc;
  logic            tmo_hit, ovf_hit;
  logic            req, wr, wr_ctrl, wr_stat, wr_tmo, clr;
  logic [2:0]      idx;
  logic [31:0]     rd_mux;
  logic            unused_bus;

  prim_sync_2ff #(.WIDTH(1)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (cio_pwm_i),
    .q_o    (lvl_sync)
  );

  // Edge-detect stage behind the synchronizer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lvl_p2 <= 1'b0;
    else         lvl_p2 <= lvl_sync;
  end

  assign rise = lvl_sync & ~lvl_p2;

  assign req     = valid_i & ~ready_o;
  assign idx     = addr_i[4:2];
  assign wr      = req & we_i;
  assign wr_ctrl = wr && (idx == OFF_CTRL);
  assign wr_stat = wr && (idx == OFF_STATUS);
  assign wr_tmo  = wr && (idx == OFF_TIMEOUT);
  assign clr     = wr_ctrl & wdata_i[CTRL_CLR];

  assign unused_bus = ^{addr_i[31:5], addr_i[1:0], wdata_i};

  // cnt+1 is formed one bit wider so an all-ones count never aliases TIMEOUT
  assign cnt_inc = {1'b0, cnt} + {{BITS{1'b0}}, 1'b1};
  assign tmo_hit = (timeout != '0) && (cnt_inc == {1'b0, timeout});
  assign ovf_hit = tmo_hit || (&cnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      period   <= '0;
      high     <= '0;
      st_valid <= 1'b0;
      st_ovf   <= 1'b0;
    end else begin
      // Software W1C first so a same-cycle hardware set below wins
      if (wr_stat && wdata_i[STAT_VALID]) st_valid <= 1'b0;
      if (wr_stat && wdata_i[STAT_OVF])   st_ovf   <= 1'b0;

      if (clr) begin
        cnt      <= '0;
        hcnt     <= '0;
        period   <= '0;
        high     <= '0;
        st_valid <= 1'b0;
        st_ovf   <= 1'b0;
        state    <= wdata_i[CTRL_EN] ? ST_ARM : ST_IDLE;
      end else if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        hcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            if (rise) begin
              cnt   <= '0;
              hcnt  <= BITS'(1);
              state <= ST_MEAS;
            end
          end
          ST_MEAS: begin
            if (rise) begin
              period   <= sat_inc(cnt);
              high     <= hcnt;
              st_valid <= 1'b1;
              cnt      <= '0;
              hcnt     <= BITS'(1);
            end else if (ovf_hit) begin
              st_ovf <= 1'b1;
              cnt    <= '0;
              hcnt   <= '0;
              state  <= ST_ARM;
            end else begin
              cnt <= sat_inc(cnt);
              if (lvl_sync) hcnt <= sat_inc(hcnt);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      OFF_CTRL:    rd_mux = {30'd0, irq_en, en};
      OFF_PERIOD:  rd_mux = 32'(period);
      OFF_HIGH:    rd_mux = 32'(high);
      OFF_STATUS:  rd_mux = {29'd0, lvl_sync, st_ovf, st_valid};
      OFF_TIMEOUT: rd_mux = 32'(timeout);
      default:     rd_mux = '0;
    endcase
  end

  // Bus response stage: ack and read data one cycle after the request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o <= 1'b0;
      rdata_o <= '0;
      irq_o   <= 1'b0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
      timeout <= '0;
    end else begin
      ready_o <= req;
      rdata_o <= (req && !we_i) ? rd_mux : '0;
      irq_o   <= irq_en & (st_valid | st_ovf);
      if (wr_ctrl) begin
        en     <= wdata_i[CTRL_EN];
        irq_en <= wdata_i[CTRL_IRQ_EN];
      end
      if (wr_tmo) timeout <= wdata_i[BITS-1:0];
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: reads push expectations, a monitor pops
// and compares them on each read acknowledge.
module tb_pwm_capture;

  localparam logic [31:0] A_CTRL    = 32'h00;
  localparam logic [31:0] A_PERIOD  = 32'h04;
  localparam logic [31:0] A_HIGH    = 32'h08;
  localparam logic [31:0] A_STATUS  = 32'h0C;
  localparam logic [31:0] A_TIMEOUT = 32'h10;
  localparam logic [31:0] A_UNMAP   = 32'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        pwm = 1'b0;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;
  exp_t exp_q[$];

  int pwm_per = 0;
  int pwm_hi = 0;
  bit pwm_force = 1'b0;
  int ph = 0;
  int last_per = 0;

  pwm_capture dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (valid),
    .ready_o   (ready_o),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata_o),
    .cio_pwm_i (pwm),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  // PWM source: periodic when pwm_per>0, otherwise follows pwm_force
  always @(posedge clk) begin
    #1;
    if (pwm_per != last_per) begin
      ph = 0;
      last_per = pwm_per;
    end
    if (pwm_per == 0) pwm = pwm_force;
    else begin
      pwm = (ph < pwm_hi);
      ph = (ph + 1 == pwm_per) ? 0 : ph + 1;
    end
  end

  // Scoreboard monitor on read acknowledges
  always @(negedge clk) begin
    if (ready_o && !we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack rdata=%h", rdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((rdata_o & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s rdata=%h expected=%h mask=%h", e.name, rdata_o, e.exp, e.mask);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_read(input string nm, input logic [31:0] a,
                          input logic [31:0] e, input logic [31:0] m);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    x.mask = m;
    @(posedge clk); #1;
    valid = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(x);
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack ready_o=%b expected=1", nm, ready_o);
    end
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    valid = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL write_ack addr=%h ready_o=%b expected=1", a, ready_o);
    end
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    wait_cyc(3); #1;
    checks++;
    if ({ready_o, irq_o, rdata_o} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b irq=%b rdata=%h expected all 0", ready_o, irq_o, rdata_o);
    end
    rst_n = 1'b1;
    bus_read("rst_ctrl", A_CTRL, 32'd0, '1);
    bus_read("rst_period", A_PERIOD, 32'd0, '1);
    bus_read("rst_status", A_STATUS, 32'd0, '1);
    bus_read("rst_timeout", A_TIMEOUT, 32'd0, '1);
  endtask

  task automatic test_regs();
    bus_write(A_TIMEOUT, 32'h1234_5678);
    bus_read("timeout_rw", A_TIMEOUT, 32'h1234_5678, '1);
    bus_write(A_CTRL, 32'h7);
    bus_read("ctrl_clr_reads0", A_CTRL, 32'h3, '1);
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    bus_read("unmapped", A_UNMAP, 32'd0, '1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_TIMEOUT, 32'h0);
  endtask

  task automatic test_period();
    bus_write(A_CTRL, 32'h5);
    pwm_hi = 3;
    pwm_per = 10;
    wait_cyc(45);
    pwm_per = 0;
    pwm_force = 1'b0;
    wait_cyc(6);
    bus_read("p10_period", A_PERIOD, 32'd10, '1);
    bus_read("p10_high", A_HIGH, 32'd3, '1);
    bus_read("p10_status", A_STATUS, 32'h1, '1);
    bus_write(A_CTRL, 32'h0);
    bus_read("en_off_period_kept", A_PERIOD, 32'd10, '1);
    bus_read("en_off_status_kept", A_STATUS, 32'h1, '1);
  endtask

  task automatic test_latency();
    bus_write(A_CTRL, 32'h7);
    wait_cyc(5);
    @(posedge clk); pwm_force = 1'b1;
    repeat (3) @(posedge clk); pwm_force = 1'b0;
    repeat (5) @(posedge clk); pwm_force = 1'b1;
    repeat (3) @(posedge clk); #2;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_irq_early irq_o=%b expected=0", irq_o);
    end
    @(posedge clk); #2;
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_irq irq_o=%b expected=1", irq_o);
    end
    bus_read("lat_period", A_PERIOD, 32'd8, '1);
    bus_read("lat_high", A_HIGH, 32'd3, '1);
    bus_read("lat_status_level", A_STATUS, 32'h5, '1);
    bus_write(A_STATUS, 32'h1);
    bus_read("w1c_valid", A_STATUS, 32'h4, '1);
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_w1c irq_o=%b expected=0", irq_o);
    end
  endtask

  task automatic test_timeout();
    pwm_force = 1'b0;
    wait_cyc(5);
    bus_write(A_TIMEOUT, 32'd50);
    bus_write(A_CTRL, 32'h7);
    wait_cyc(3);
    @(posedge clk); pwm_force = 1'b1;
    repeat (53) @(posedge clk); #2;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_irq_early irq_o=%b expected=0", irq_o);
    end
    @(posedge clk); #2;
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_irq irq_o=%b expected=1", irq_o);
    end
    bus_read("ovf_status", A_STATUS, 32'h6, '1);
    bus_read("ovf_period_kept", A_PERIOD, 32'd0, '1);
    bus_write(A_STATUS, 32'h2);
    wait_cyc(60);
    bus_read("ovf_back_to_arm", A_STATUS, 32'h4, '1);
    bus_write(A_TIMEOUT, 32'h0);
  endtask

  task automatic test_w1c_race();
    pwm_force = 1'b0;
    wait_cyc(4);
    bus_write(A_CTRL, 32'h5);
    wait_cyc(3);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); pwm_force = 1'b1;
      repeat (2) @(posedge clk); pwm_force = 1'b0;
      repeat (6) @(posedge clk);
    end
    bus_read("race_pre_valid", A_STATUS, 32'h1, 32'h3);
    @(posedge clk); pwm_force = 1'b1;
    @(posedge clk);
    bus_write(A_STATUS, 32'h1);
    wait_cyc(1);
    pwm_force = 1'b0;
    wait_cyc(6);
    bus_read("race_hw_wins", A_STATUS, 32'h1, 32'h3);
    bus_write(A_STATUS, 32'h1);
    bus_read("race_w1c_plain", A_STATUS, 32'h0, 32'h3);
  endtask

  task automatic test_clr();
    bus_write(A_CTRL, 32'h5);
    pwm_hi = 5;
    pwm_per = 20;
    wait_cyc(30);
    bus_write(A_CTRL, 32'h5);
    bus_read("clr_period", A_PERIOD, 32'd0, '1);
    bus_read("clr_high", A_HIGH, 32'd0, '1);
    bus_read("clr_flags", A_STATUS, 32'd0, 32'h3);
    wait_cyc(60);
    pwm_per = 0;
    pwm_force = 1'b0;
    wait_cyc(6);
    bus_read("p20_period", A_PERIOD, 32'd20, '1);
    bus_read("p20_high", A_HIGH, 32'd5, '1);
    bus_read("p20_valid", A_STATUS, 32'h1, 32'h3);
  endtask

  task automatic test_reset_mid();
    bus_write(A_CTRL, 32'h3);
    pwm_hi = 3;
    pwm_per = 10;
    wait_cyc(35);
    #1;
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_irq irq_o=%b expected=1", irq_o);
    end
    @(posedge clk); #1;
    valid = 1'b1; we = 1'b0; addr = A_PERIOD;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || rdata_o !== 32'd10) begin
      errors++;
      $display("FAIL mid_read_ack ready=%b rdata=%h expected 1/0000000a", ready_o, rdata_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_o, irq_o, rdata_o} !== 34'd0) begin
      errors++;
      $display("FAIL reset_immediate ready=%b irq=%b rdata=%h expected all 0", ready_o, irq_o, rdata_o);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    valid = 1'b1; addr = A_CTRL;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_txn ready_o=%b expected=0", ready_o);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL no_late_ack ready_o=%b expected=0", ready_o);
    end
    bus_read("post_rst_ctrl", A_CTRL, 32'd0, '1);
    bus_read("post_rst_period", A_PERIOD, 32'd0, '1);
    bus_read("post_rst_flags", A_STATUS, 32'd0, 32'h3);
    pwm_per = 0;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_period();
    test_latency();
    test_timeout();
    test_w1c_race();
    test_clr();
    test_reset_mid();
    wait_cyc(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_acks pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "bench did not finish");
  end

endmodule
